order_book_engine: RTL and testbench
====================================

Name: order_book_engine

Overview:
- Parametrised multi-symbol limit order book for the HFT feed path. It takes decoded add, cancel and modify messages and stores them in per-symbol, per-side slot tables.
- After each successful change it recomputes the best bid and best ask for the affected book, including aggregate quantity at the best price.
- It sits downstream of the symbol decoder and message parser, which supply the symbol index. Strategy logic reads top-of-book through a query port.

Parameters:
- NUM_SYM, 5, number of symbols (books).
- DEPTH, 8, order slots per side per symbol; must be ≥2.
- PRICE_W, 64, price width.
- QTY_W, 64, quantity width.
- ID_W, 32, order ID width.
- SYM_IW, 3, symbol index width; must satisfy 2^SYM_IW ≥ NUM_SYM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- msg_valid  in  1  message present.
- msg_ready  out  1  engine can accept a message.
- msg_type  in  2  00=add, 01=cancel, 10=modify, 11=reserved.
- sym_idx  in  SYM_IW  symbol book index.
- side  in  1  1=bid, 0=ask.
- price  in  PRICE_W  new price (add/modify).
- quantity  in  QTY_W  new quantity (add/modify).
- order_id  in  ID_W  new order ID (add/modify).
- orig_order_id  in  ID_W  target order ID (cancel/modify).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  2  00=OK, 01=FULL, 10=NOT_FOUND, 11=REJECT.
- rsp_order_id  out  ID_W  order_id for add; orig_order_id for cancel/modify.
- q_sym  in  SYM_IW  top-of-book query index.
- best_bid_vld  out  1  bid book of q_sym non-empty.
- best_bid_px  out  PRICE_W  best bid price.
- best_bid_qty  out  QTY_W  aggregate bid quantity at best bid price.
- best_ask_vld  out  1  ask book of q_sym non-empty.
- best_ask_px  out  PRICE_W  best ask price.
- best_ask_qty  out  QTY_W  aggregate ask quantity at best ask price.

Behaviour:
- The single clock is clk. Reset rst is synchronous and active-high.
- Reset clears:
  - all slot valid bits, prices, quantities and IDs;
  - all per-symbol best registers (vld=0, px=0, qty=0);
  - the FSM, which returns to IDLE;
  - rsp_valid, rsp_status and rsp_order_id, all to 0.
- msg_ready=1 from the first cycle after reset. Reset mid-operation aborts the operation with no response; table state is cleared.
- FSM states: IDLE, EXEC, SCAN. msg_ready = (state==IDLE).
- IDLE: on msg_valid&msg_ready at edge E0, register all message fields and go to EXEC.
- EXEC: single-cycle parallel compare over the DEPTH slots of book (sym_idx, side). Writes occur at edge E1, and rsp_valid is high for the one cycle after E1.
  - Add: REJECT if quantity==0 or order_id matches a valid slot. Otherwise write the lowest-index free slot and return OK. Return FULL if no slot is free.
  - Cancel: clear the valid slot with ID==orig_order_id and return OK. Return NOT_FOUND if none matches.
  - Modify: REJECT if quantity==0, or if order_id!=orig_order_id and order_id already exists in the book. Otherwise overwrite price, quantity and ID in the matching slot (slot index kept) and return OK. Return NOT_FOUND if there is no match.
  - REJECT with no table change for sym_idx≥NUM_SYM or msg_type==11.
  - Non-OK status returns to IDLE at E1. OK goes to SCAN.
- SCAN: iterate slots 0..DEPTH-1 of the modified book, one slot per cycle, at edges E2..E(DEPTH+1).
  - Bid best is the maximum price; ask best is the minimum price. Compares are unsigned.
  - Equal price adds quantity to the running aggregate, saturating at 2^QTY_W-1.
  - At E(DEPTH+1), commit vld/px/qty to that symbol's best registers and return to IDLE. An empty book commits vld=0, px=0, qty=0.
  - The other side and other symbols are untouched.
- Accept-to-accept spacing: DEPTH+2 cycles for OK, 2 cycles otherwise.
- Query outputs are combinational reads of the best registers indexed by q_sym. They change only at SCAN commit.
- For q_sym≥NUM_SYM, all query outputs are 0.
- msg_valid with msg_ready=0 is ignored; the upstream holds the message until accepted.

Test Plan:
- After reset, q_sym=0 → best_bid_vld=0, best_ask_vld=0, msg_ready=1. A message accepted at E0 → rsp_valid high exactly one cycle after E1.
- sym 1 bid adds: (px 100, qty 10, id 1), (px 105, qty 5, id 2), (px 105, qty 7, id 3), each OK. After the last commit: best_bid_px=105, best_bid_qty=12, best_ask_vld=0.
- Fill all 8 bid slots of sym 2 (ids 10..17), then add id 18 → FULL, no best change. Cancel id 13 → OK. Re-add id 18 → OK, stored in slot 3.
- Cancel id 99 on sym 1 bid → NOT_FOUND, msg_ready high again 2 cycles after accept. Add with duplicate id 2 → REJECT. Add with qty 0 → REJECT. Add with sym_idx 6 → REJECT.
- sym 3 asks: (px 50, id 20), (px 40, id 21). Modify orig 21 → id 22, px 60, qty 3 → OK. Result: best_ask_px=50. Cancel id 20 → best_ask_px=60, best_ask_qty=3. Cancel id 22 → best_ask_vld=0.
- Assert rst during SCAN after an OK add → no rsp_valid afterwards, all books empty, msg_ready=1 in the cycle after rst deasserts. Two quantities of 2^64-1 at the same price → best_qty=2^64-1 (saturated).

Source files
------------

// File: rtl/order_book_engine.sv
// Multi-symbol limit order book: per-symbol/per-side slot tables with add/cancel/modify
// and a slot-serial rescan that maintains best price and aggregate quantity per book.

module obe_slot_cmp #(
  parameter int ID_W = 32
) (
  input  logic            vld,
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] new_id,
  input  logic [ID_W-1:0] orig_id,
  output logic            hit_new,
  output logic            hit_orig
);
  assign hit_new  = vld && (id == new_id);
  assign hit_orig = vld && (id == orig_id);
endmodule

module order_book_engine #(
  parameter int NUM_SYM = 5,
  parameter int DEPTH   = 8,
  parameter int PRICE_W = 64,
  parameter int QTY_W   = 64,
  parameter int ID_W    = 32,
  parameter int SYM_IW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [1:0]         msg_type,
  input  logic [SYM_IW-1:0]  sym_idx,
  input  logic               side,
  input  logic [PRICE_W-1:0] price,
  input  logic [QTY_W-1:0]   quantity,
  input  logic [ID_W-1:0]    order_id,
  input  logic [ID_W-1:0]    orig_order_id,
  output logic               rsp_valid,
  output logic [1:0]         rsp_status,
  output logic [ID_W-1:0]    rsp_order_id,
  input  logic [SYM_IW-1:0]  q_sym,
  output logic               best_bid_vld,
  output logic [PRICE_W-1:0] best_bid_px,
  output logic [QTY_W-1:0]   best_bid_qty,
  output logic               best_ask_vld,
  output logic [PRICE_W-1:0] best_ask_px,
  output logic [QTY_W-1:0]   best_ask_qty
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] T_ADD = 2'b00, T_CAN = 2'b01, T_MOD = 2'b10;
  localparam logic [1:0] ST_OK = 2'b00, ST_FULL = 2'b01, ST_NF = 2'b10, ST_REJ = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, SCAN} state_t;
  state_t state;

  logic [1:0]         m_type;
  logic [SYM_IW-1:0]  m_sym;
  logic               m_side;
  logic [PRICE_W-1:0] m_px;
  logic [QTY_W-1:0]   m_qty;
  logic [ID_W-1:0]    m_id, m_orig;

  logic [DEPTH-1:0]   tbl_vld [NUM_SYM][2];
  logic [PRICE_W-1:0] tbl_px  [NUM_SYM][2][DEPTH];
  logic [QTY_W-1:0]   tbl_qty [NUM_SYM][2][DEPTH];
  logic [ID_W-1:0]    tbl_id  [NUM_SYM][2][DEPTH];

  logic               best_vld [NUM_SYM][2];
  logic [PRICE_W-1:0] best_px  [NUM_SYM][2];
  logic [QTY_W-1:0]   best_qty [NUM_SYM][2];

  logic               acc_vld;
  logic [PRICE_W-1:0] acc_px;
  logic [QTY_W-1:0]   acc_qty;
  logic [IW-1:0]      scan_idx;

  assign msg_ready = (state == IDLE);

  // Out-of-range symbols are rejected; clamp so the table read stays in bounds.
  logic              sym_ok;
  logic [SYM_IW-1:0] sc;
  assign sym_ok = int'(m_sym) < NUM_SYM;
  assign sc     = sym_ok ? m_sym : '0;

  logic [DEPTH-1:0] book_vld, hit_new, hit_orig;
  assign book_vld = tbl_vld[sc][m_side];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    obe_slot_cmp #(.ID_W(ID_W)) u_cmp (
      .vld     (book_vld[g]),
      .id      (tbl_id[sc][m_side][g]),
      .new_id  (m_id),
      .orig_id (m_orig),
      .hit_new (hit_new[g]),
      .hit_orig(hit_orig[g])
    );
  end

  logic [IW-1:0] free_idx, orig_idx, ex_idx;
  logic [1:0]    ex_status;
  logic          ex_wr, ex_clr;

  always_comb begin
    free_idx = '0;
    orig_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!book_vld[i]) free_idx = IW'(i);
      if (hit_orig[i])  orig_idx = IW'(i);
    end
  end

  always_comb begin
    ex_status = ST_REJ;
    ex_wr     = 1'b0;
    ex_clr    = 1'b0;
    ex_idx    = '0;
    if (sym_ok) begin
      case (m_type)
        T_ADD: begin
          if (m_qty == '0 || |hit_new) ex_status = ST_REJ;
          else if (&book_vld)          ex_status = ST_FULL;
          else begin
            ex_status = ST_OK; ex_wr = 1'b1; ex_idx = free_idx;
          end
        end
        T_CAN: begin
          if (|hit_orig) begin
            ex_status = ST_OK; ex_clr = 1'b1; ex_idx = orig_idx;
          end else ex_status = ST_NF;
        end
        T_MOD: begin
          if (m_qty == '0 || (m_id != m_orig && |hit_new)) ex_status = ST_REJ;
          else if (|hit_orig) begin
            ex_status = ST_OK; ex_wr = 1'b1; ex_idx = orig_idx;
          end else ex_status = ST_NF;
        end
        default: ex_status = ST_REJ;
      endcase
    end
  end

  // One scan step: fold slot scan_idx into the running best/aggregate.
  logic               s_vld, nxt_vld;
  logic [PRICE_W-1:0] s_px, nxt_px;
  logic [QTY_W-1:0]   s_qty, nxt_qty;
  logic [QTY_W:0]     qsum;
  assign s_vld = tbl_vld[sc][m_side][scan_idx];
  assign s_px  = tbl_px[sc][m_side][scan_idx];
  assign s_qty = tbl_qty[sc][m_side][scan_idx];
  assign qsum  = {1'b0, acc_qty} + {1'b0, s_qty};

  always_comb begin
    nxt_vld = acc_vld;
    nxt_px  = acc_px;
    nxt_qty = acc_qty;
    if (s_vld) begin
      if (!acc_vld || (m_side ? (s_px > acc_px) : (s_px < acc_px))) begin
        nxt_vld = 1'b1; nxt_px = s_px; nxt_qty = s_qty;
      end else if (s_px == acc_px) begin
        nxt_qty = qsum[QTY_W] ? '1 : qsum[QTY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_type       <= '0;
      m_sym        <= '0;
      m_side       <= 1'b0;
      m_px         <= '0;
      m_qty        <= '0;
      m_id         <= '0;
      m_orig       <= '0;
      acc_vld      <= 1'b0;
      acc_px       <= '0;
      acc_qty      <= '0;
      scan_idx     <= '0;
      rsp_valid    <= 1'b0;
      rsp_status   <= '0;
      rsp_order_id <= '0;
      for (int s = 0; s < NUM_SYM; s++) begin
        for (int b = 0; b < 2; b++) begin
          tbl_vld[s][b]  <= '0;
          best_vld[s][b] <= 1'b0;
          best_px[s][b]  <= '0;
          best_qty[s][b] <= '0;
          for (int d = 0; d < DEPTH; d++) begin
            tbl_px[s][b][d]  <= '0;
            tbl_qty[s][b][d] <= '0;
            tbl_id[s][b][d]  <= '0;
          end
        end
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (msg_valid) begin
            m_type <= msg_type;
            m_sym  <= sym_idx;
            m_side <= side;
            m_px   <= price;
            m_qty  <= quantity;
            m_id   <= order_id;
            m_orig <= orig_order_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid    <= 1'b1;
          rsp_status   <= ex_status;
          rsp_order_id <= (m_type == T_ADD) ? m_id : m_orig;
          if (ex_wr) begin
            tbl_vld[sc][m_side][ex_idx] <= 1'b1;
            tbl_px[sc][m_side][ex_idx]  <= m_px;
            tbl_qty[sc][m_side][ex_idx] <= m_qty;
            tbl_id[sc][m_side][ex_idx]  <= m_id;
          end
          if (ex_clr) tbl_vld[sc][m_side][ex_idx] <= 1'b0;
          acc_vld  <= 1'b0;
          acc_px   <= '0;
          acc_qty  <= '0;
          scan_idx <= '0;
          state    <= (ex_status == ST_OK) ? SCAN : IDLE;
        end
        SCAN: begin
          acc_vld  <= nxt_vld;
          acc_px   <= nxt_px;
          acc_qty  <= nxt_qty;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == IW'(DEPTH-1)) begin
            best_vld[sc][m_side] <= nxt_vld;
            best_px[sc][m_side]  <= nxt_px;
            best_qty[sc][m_side] <= nxt_qty;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic              q_ok;
  logic [SYM_IW-1:0] qc;
  assign q_ok = int'(q_sym) < NUM_SYM;
  assign qc   = q_ok ? q_sym : '0;

  always_comb begin
    best_bid_vld = 1'b0;
    best_bid_px  = '0;
    best_bid_qty = '0;
    best_ask_vld = 1'b0;
    best_ask_px  = '0;
    best_ask_qty = '0;
    if (q_ok) begin
      best_bid_vld = best_vld[qc][1];
      best_bid_px  = best_px[qc][1];
      best_bid_qty = best_qty[qc][1];
      best_ask_vld = best_vld[qc][0];
      best_ask_px  = best_px[qc][0];
      best_ask_qty = best_qty[qc][0];
    end
  end
endmodule

// File: tb/tb_order_book_engine.sv
// Scoreboard bench for order_book_engine: directed scenarios plus random traffic against
// an array-based order book model with two-pass best/aggregate computation.

module tb_order_book_engine;
  localparam int NUM_SYM = 5, DEPTH = 8, PW = 64, QW = 64, IDW = 32, SIW = 3;

  logic           clk, rst;
  logic           msg_valid, msg_ready, side;
  logic [1:0]     msg_type;
  logic [SIW-1:0] sym_idx, q_sym;
  logic [PW-1:0]  price;
  logic [QW-1:0]  quantity;
  logic [IDW-1:0] order_id, orig_order_id;
  logic           rsp_valid;
  logic [1:0]     rsp_status;
  logic [IDW-1:0] rsp_order_id;
  logic           best_bid_vld, best_ask_vld;
  logic [PW-1:0]  best_bid_px, best_ask_px;
  logic [QW-1:0]  best_bid_qty, best_ask_qty;

  order_book_engine #(.NUM_SYM(NUM_SYM), .DEPTH(DEPTH), .PRICE_W(PW), .QTY_W(QW),
                      .ID_W(IDW), .SYM_IW(SIW)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_type(msg_type), .sym_idx(sym_idx), .side(side), .price(price),
    .quantity(quantity), .order_id(order_id), .orig_order_id(orig_order_id),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_order_id(rsp_order_id),
    .q_sym(q_sym), .best_bid_vld(best_bid_vld), .best_bid_px(best_bid_px),
    .best_bid_qty(best_bid_qty), .best_ask_vld(best_ask_vld),
    .best_ask_px(best_ask_px), .best_ask_qty(best_ask_qty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference book: plain slot arrays, lowest free slot on add.
  bit          mv   [NUM_SYM][2][DEPTH];
  logic [63:0] mpx  [NUM_SYM][2][DEPTH];
  logic [63:0] mqty [NUM_SYM][2][DEPTH];
  logic [31:0] mid  [NUM_SYM][2][DEPTH];

  task automatic model_clear();
    for (int s = 0; s < NUM_SYM; s++)
      for (int b = 0; b < 2; b++)
        for (int d = 0; d < DEPTH; d++) mv[s][b][d] = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] t, input int s, input bit sd,
                             input logic [63:0] px, input logic [63:0] qty,
                             input logic [31:0] id, input logic [31:0] orig,
                             output logic [1:0] st);
    int hn, ho, fr;
    hn = -1; ho = -1; fr = -1;
    st = 2'd3;
    if (s >= NUM_SYM || t == 2'd3) return;
    for (int d = 0; d < DEPTH; d++) begin
      if (mv[s][sd][d]) begin
        if (mid[s][sd][d] == id && hn < 0)   hn = d;
        if (mid[s][sd][d] == orig && ho < 0) ho = d;
      end else if (fr < 0) fr = d;
    end
    if (t == 2'd0) begin
      if (qty == 0 || hn >= 0) st = 2'd3;
      else if (fr < 0) st = 2'd1;
      else begin
        st = 2'd0;
        mv[s][sd][fr] = 1'b1; mpx[s][sd][fr] = px; mqty[s][sd][fr] = qty; mid[s][sd][fr] = id;
      end
    end else if (t == 2'd1) begin
      if (ho >= 0) begin st = 2'd0; mv[s][sd][ho] = 1'b0; end
      else st = 2'd2;
    end else begin
      if (qty == 0 || (id != orig && hn >= 0)) st = 2'd3;
      else if (ho >= 0) begin
        st = 2'd0; mpx[s][sd][ho] = px; mqty[s][sd][ho] = qty; mid[s][sd][ho] = id;
      end else st = 2'd2;
    end
  endtask

  task automatic model_best(input int s, input bit sd, output bit v,
                            output logic [63:0] px, output logic [63:0] qty);
    logic [71:0] sum;
    v = 1'b0; px = '0; qty = '0; sum = '0;
    if (s >= NUM_SYM) return;
    for (int d = 0; d < DEPTH; d++)
      if (mv[s][sd][d] && (!v || (sd ? mpx[s][sd][d] > px : mpx[s][sd][d] < px))) begin
        v = 1'b1; px = mpx[s][sd][d];
      end
    if (v) begin
      for (int d = 0; d < DEPTH; d++)
        if (mv[s][sd][d] && mpx[s][sd][d] == px) sum = sum + {8'd0, mqty[s][sd][d]};
      qty = (sum > 72'h00FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
    end
  endtask

  logic [IDW+1:0] exp_q[$];
  logic [IDW+1:0] mon_e;

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(mon_e[IDW+1:IDW]));
        chk("rsp_id", 64'(rsp_order_id), 64'(mon_e[IDW-1:0]));
      end
    end
  end

  task automatic check_top(input int s, input string tag);
    bit v; logic [63:0] px, qty;
    q_sym = SIW'(s);
    #1;
    model_best(s, 1'b1, v, px, qty);
    chk({tag, "_bid_vld"}, 64'(best_bid_vld), 64'(v));
    chk({tag, "_bid_px"}, best_bid_px, px);
    chk({tag, "_bid_qty"}, best_bid_qty, qty);
    model_best(s, 1'b0, v, px, qty);
    chk({tag, "_ask_vld"}, 64'(best_ask_vld), 64'(v));
    chk({tag, "_ask_px"}, best_ask_px, px);
    chk({tag, "_ask_qty"}, best_ask_qty, qty);
  endtask

  task automatic send(input logic [1:0] t, input int s, input bit sd,
                      input logic [63:0] px, input logic [63:0] qty,
                      input logic [31:0] id, input logic [31:0] orig);
    logic [1:0] st; bit pv; logic [63:0] ppx, pq; int k;
    @(negedge clk);
    msg_type = t; sym_idx = SIW'(s); side = sd; price = px; quantity = qty;
    order_id = id; orig_order_id = orig; msg_valid = 1'b1; q_sym = SIW'(s);
    k = 0;
    while (!msg_ready && k < 50) begin @(negedge clk); k++; end
    if (!msg_ready) begin chk("ready_timeout", 64'd0, 64'd1); msg_valid = 1'b0; return; end
    model_best(s, sd, pv, ppx, pq);
    model_apply(t, s, sd, px, qty, id, orig, st);
    exp_q.push_back({st, (t == 2'd0) ? id : orig});
    @(posedge clk); #1;
    msg_valid = 1'b0;
    chk("rsp_early", 64'(rsp_valid), 64'd0);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (k == 1) begin
        chk("rsp_latency", 64'(rsp_valid), 64'd1);
        chk("hold_px", sd ? best_bid_px : best_ask_px, ppx);
      end
    end while (!msg_ready && k < DEPTH + 20);
    chk("spacing", 64'(k), (st == 2'd0) ? 64'(DEPTH + 1) : 64'd1);
    check_top(s, "top");
  endtask

  initial begin
    logic [1:0] st;
    rst = 1'b1; msg_valid = 1'b0; msg_type = '0; sym_idx = '0; side = 1'b0;
    price = '0; quantity = '0; order_id = '0; orig_order_id = '0; q_sym = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", 64'(msg_ready), 64'd1);
    chk("reset_bid_vld", 64'(best_bid_vld), 64'd0);
    chk("reset_ask_vld", 64'(best_ask_vld), 64'd0);

    send(2'd0, 1, 1'b1, 100, 10, 1, 0);
    send(2'd0, 1, 1'b1, 105, 5, 2, 0);
    send(2'd0, 1, 1'b1, 105, 7, 3, 0);
    chk("sym1_bid_px", best_bid_px, 64'd105);
    chk("sym1_bid_qty", best_bid_qty, 64'd12);
    chk("sym1_ask_vld", 64'(best_ask_vld), 64'd0);

    for (int i = 0; i < 8; i++) send(2'd0, 2, 1'b1, 64'(200 + i), 1, 32'(10 + i), 0);
    send(2'd0, 2, 1'b1, 300, 1, 18, 0);
    chk("full_no_change", best_bid_px, 64'd207);
    send(2'd1, 2, 1'b1, 0, 0, 0, 13);
    send(2'd0, 2, 1'b1, 300, 1, 18, 0);
    chk("readd_best", best_bid_px, 64'd300);

    send(2'd1, 1, 1'b1, 0, 0, 0, 99);
    send(2'd0, 1, 1'b1, 110, 1, 2, 0);
    send(2'd0, 1, 1'b1, 110, 0, 50, 0);
    send(2'd0, 6, 1'b1, 1, 1, 51, 0);
    send(2'd3, 1, 1'b1, 1, 1, 52, 0);

    send(2'd0, 3, 1'b0, 50, 4, 20, 0);
    send(2'd0, 3, 1'b0, 40, 2, 21, 0);
    send(2'd2, 3, 1'b0, 60, 3, 22, 21);
    chk("mod_ask_px", best_ask_px, 64'd50);
    send(2'd1, 3, 1'b0, 0, 0, 0, 20);
    chk("can_ask_px", best_ask_px, 64'd60);
    chk("can_ask_qty", best_ask_qty, 64'd3);
    send(2'd1, 3, 1'b0, 0, 0, 0, 22);
    chk("empty_ask_vld", 64'(best_ask_vld), 64'd0);

    send(2'd0, 4, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FFFF, 30, 0);
    send(2'd0, 4, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FFFF, 31, 0);
    chk("sat_qty", best_ask_qty, 64'hFFFF_FFFF_FFFF_FFFF);
    check_top(6, "q6");
    check_top(7, "q7");

    // Reset landing in the middle of a rescan.
    @(negedge clk);
    msg_type = 2'd0; sym_idx = 0; side = 1'b1; price = 5; quantity = 5;
    order_id = 40; orig_order_id = 0; msg_valid = 1'b1;
    model_apply(2'd0, 0, 1'b1, 5, 5, 40, 0, st);
    exp_q.push_back({st, 32'd40});
    @(posedge clk); #1 msg_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_mid_ready", 64'(msg_ready), 64'd1);
    for (int s = 0; s < NUM_SYM; s++) check_top(s, "rst_mid");
    repeat (12) @(posedge clk);

    for (int n = 0; n < 200; n++) begin
      int r, s; bit sd; logic [63:0] px, qty; logic [31:0] id, orig; logic [1:0] t;
      r = $urandom_range(0, 15);
      t = (r < 7) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      s = $urandom_range(0, 5);
      sd = 1'($urandom_range(0, 1));
      px = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      qty = (r == 0) ? 64'd0 : (r == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'($urandom_range(1, 100));
      orig = 32'($urandom_range(0, 15));
      id = ($urandom_range(0, 1) == 1) ? orig : 32'($urandom_range(0, 15));
      send(t, s, sd, px, qty, id, orig);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
